// File: rtl/mcfsm_pkg.sv
// Shared encodings for the multicycle RV32I sequencing controller: states,
// opcodes, ALU function codes and datapath select codes.
package mcfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/mc_alu_func_decode.sv
// ALU function decode for R-type and I-type execute states.
module mc_alu_func_decode
  import mcfsm_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // funct7b5 only selects sub for R-type; addi immediates may have bit 30 set
      3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b100:  alu_control = ALU_XOR;
      3'b101:  alu_control = ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional MCFSM_ILLEGAL_TRAP_EN sends unsupported opcodes to a sticky HALT state.
module multicycle_control_fsm
  import mcfsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       signflag,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  state_e     state_q, state_d;
  logic [2:0] alu_func;

  mc_alu_func_decode u_alu_dec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_control(alu_func)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    reg_write   = 1'b0;
    alu_control = ALU_ADD;
    illegal_o   = 1'b0;
    state_o     = state_q;

    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // branch target OldPC + immB lands in ALUOut for BRANCH to use
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BRANCH:    state_d = S_BRANCH;
`ifdef MCFSM_ILLEGAL_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = op[5] ? IMM_S : IMM_I;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = alu_func;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        alu_control = alu_func;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        pc_write    = ((funct3 == 3'b000) &&  zero) ||
                      ((funct3 == 3'b001) && !zero) ||
                      ((funct3 == 3'b100) &&  signflag);
        state_d     = S_FETCH;
      end
      S_HALT: begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
        illegal_o = 1'b1;
`endif
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    // async reset must silence every output, including the FETCH read request
    if (rst) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      reg_write   = 1'b0;
      alu_control = 3'b000;
      illegal_o   = 1'b0;
      state_o     = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, signflag, mem_ready;
  logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal_o;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic [21:0] all_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .signflag(signflag), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .alu_control(alu_control), .state_o(state_o),
    .illegal_o(illegal_o)
  );

  assign all_out = {pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
                    alu_src_a, alu_src_b, imm_src, reg_write, alu_control, state_o, illegal_o};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = RT; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; signflag = 1'b0;
    #2;
    n_checks++;
    if (all_out !== 22'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    tick();
    n_checks++;
    if (all_out !== 22'd0) begin
      n_fail++; $display("FAIL reset_held: got %h want 0", all_out);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1 ||
        adr_src !== 1'b0 || alu_src_b !== 2'b10 || result_src !== 2'b10 || alu_control !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_fetch: state=%0d mr=%b irw=%b pcw=%b adr=%b srcb=%b res=%b alu=%b want 0 1 1 1 0 10 10 000",
               state_o, mem_read, ir_write, pc_write, adr_src, alu_src_b, result_src, alu_control);
    end
  endtask

  task automatic test_rtype_add();
    op = RT; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    #1;
    tick();
    n_checks++;
    if (state_o !== 4'd1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || imm_src !== 2'b10 ||
        pc_write !== 1'b0 || ir_write !== 1'b0 || reg_write !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL add_decode: state=%0d srca=%b srcb=%b imm=%b pcw=%b irw=%b rw=%b mr=%b want 1 01 01 10 0 0 0 0",
               state_o, alu_src_a, alu_src_b, imm_src, pc_write, ir_write, reg_write, mem_read);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd6 || alu_control !== 3'b000 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00 ||
        reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL add_execr: state=%0d alu=%b srca=%b srcb=%b rw=%b want 6 000 10 00 0",
               state_o, alu_control, alu_src_a, alu_src_b, reg_write);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd8 || reg_write !== 1'b1 || result_src !== 2'b00 || pc_write !== 1'b0) begin
      n_fail++;
      $display("FAIL add_aluwb: state=%0d rw=%b res=%b pcw=%b want 8 1 00 0",
               state_o, reg_write, result_src, pc_write);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd0 || reg_write !== 1'b0) begin
      n_fail++; $display("FAIL add_return: state=%0d rw=%b want 0 0", state_o, reg_write);
    end
  endtask

  task automatic test_sub_addi();
    op = RT; funct3 = 3'b000; funct7b5 = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (state_o !== 4'd6 || alu_control !== 3'b010) begin
      n_fail++; $display("FAIL sub_execr: state=%0d alu=%b want 6 010", state_o, alu_control);
    end
    tick(); tick();
    op = IT;
    tick(); tick();
    n_checks++;
    if (state_o !== 4'd7 || alu_control !== 3'b000 || alu_src_a !== 2'b10 ||
        alu_src_b !== 2'b01 || imm_src !== 2'b00) begin
      n_fail++;
      $display("FAIL addi_execi: state=%0d alu=%b srca=%b srcb=%b imm=%b want 7 000 10 01 00",
               state_o, alu_control, alu_src_a, alu_src_b, imm_src);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd8 || reg_write !== 1'b1) begin
      n_fail++; $display("FAIL addi_aluwb: state=%0d rw=%b want 8 1", state_o, reg_write);
    end
    tick();
  endtask

  task automatic test_alu_funcs();
    logic [2:0] exp_alu [8] = '{3'b010, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
    op = RT; funct7b5 = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      funct3 = 3'(i);
      tick(); tick();
      n_checks++;
      if (state_o !== 4'd6 || alu_control !== exp_alu[i]) begin
        n_fail++;
        $display("FAIL alu_func_f3_%0d: state=%0d alu=%b want 6 %b", i, state_o, alu_control, exp_alu[i]);
      end
      tick(); tick();
    end
    funct3 = 3'b110; op = IT; funct7b5 = 1'b0;
    tick(); tick();
    n_checks++;
    if (state_o !== 4'd7 || alu_control !== 3'b110) begin
      n_fail++; $display("FAIL ori_execi: state=%0d alu=%b want 7 110", state_o, alu_control);
    end
    tick(); tick();
  endtask

  task automatic test_lw_stall();
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (state_o !== 4'd2 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01 || imm_src !== 2'b00 ||
        mem_read !== 1'b0 || alu_control !== 3'b000) begin
      n_fail++;
      $display("FAIL lw_memadr: state=%0d srca=%b srcb=%b imm=%b mr=%b alu=%b want 2 10 01 00 0 000",
               state_o, alu_src_a, alu_src_b, imm_src, mem_read, alu_control);
    end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (state_o !== 4'd3 || mem_read !== 1'b1 || adr_src !== 1'b1 || reg_write !== 1'b0) begin
        n_fail++;
        $display("FAIL lw_memread_stall_%0d: state=%0d mr=%b adr=%b rw=%b want 3 1 1 0",
                 i, state_o, mem_read, adr_src, reg_write);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state_o !== 4'd3 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL lw_memread_done: state=%0d mr=%b want 3 1", state_o, mem_read);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd4 || result_src !== 2'b01 || reg_write !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_memwb: state=%0d res=%b rw=%b mr=%b want 4 01 1 0",
               state_o, result_src, reg_write, mem_read);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL lw_return: state=%0d want 0", state_o);
    end
  endtask

  task automatic test_sw_fetch_stall();
    op = SW; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_stall: state=%0d mr=%b irw=%b pcw=%b want 0 1 0 0",
               state_o, mem_read, ir_write, pc_write);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state_o !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_ready: state=%0d irw=%b pcw=%b want 0 1 1", state_o, ir_write, pc_write);
    end
    tick(); tick();
    n_checks++;
    if (state_o !== 4'd2 || imm_src !== 2'b01) begin
      n_fail++; $display("FAIL sw_memadr: state=%0d imm=%b want 2 01", state_o, imm_src);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd5 || mem_write !== 1'b1 || adr_src !== 1'b1 || mem_read !== 1'b0 ||
        reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_memwrite: state=%0d mw=%b adr=%b mr=%b rw=%b want 5 1 1 0 0",
               state_o, mem_write, adr_src, mem_read, reg_write);
    end
    tick();
    n_checks++;
    if (state_o !== 4'd0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL sw_return: state=%0d mw=%b want 0 0", state_o, mem_write);
    end
  endtask

  task automatic test_branches();
    logic [2:0] f3 [7]  = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b000, 3'b000, 3'b010};
    logic       zv [7]  = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1};
    logic       sv [7]  = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
    logic       exp [7] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
    op = BR; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      funct3 = f3[i]; zero = 1'b0; signflag = 1'b0;
      tick(); tick();
      zero = zv[i]; signflag = sv[i];
      #1;
      n_checks++;
      if (state_o !== 4'd9 || pc_write !== exp[i] || alu_control !== 3'b010 ||
          alu_src_a !== 2'b10 || alu_src_b !== 2'b00 || reg_write !== 1'b0) begin
        n_fail++;
        $display("FAIL branch_%0d: state=%0d pcw=%b alu=%b srca=%b srcb=%b rw=%b want 9 %b 010 10 00 0",
                 i, state_o, pc_write, alu_control, alu_src_a, alu_src_b, reg_write, exp[i]);
      end
      tick();
      n_checks++;
      if (state_o !== 4'd0) begin
        n_fail++; $display("FAIL branch_return_%0d: state=%0d want 0", i, state_o);
      end
    end
    zero = 1'b0; signflag = 1'b0;
  endtask

  task automatic test_reset_mid_memwrite();
    op = SW; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (state_o !== 4'd5 || mem_write !== 1'b1) begin
      n_fail++; $display("FAIL memwrite_stalled: state=%0d mw=%b want 5 1", state_o, mem_write);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (all_out !== 22'd0) begin
      n_fail++; $display("FAIL rst_async_abort: got %h want 0", all_out);
    end
    tick();
    n_checks++;
    if (all_out !== 22'd0) begin
      n_fail++; $display("FAIL rst_cycle_after: got %h want 0", all_out);
    end
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state_o !== 4'd0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: state=%0d mr=%b mw=%b want 0 1 0", state_o, mem_read, mem_write);
    end
  endtask

  task automatic test_illegal();
    op = 7'b1111111; mem_ready = 1'b1;
    tick();
    n_checks++;
    if (state_o !== 4'd1) begin
      n_fail++; $display("FAIL illegal_decode: state=%0d want 1", state_o);
    end
    tick();
`ifdef MCFSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (state_o !== 4'd10 || illegal_o !== 1'b1 || mem_read !== 1'b0 || ir_write !== 1'b0 ||
          pc_write !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_halt_%0d: state=%0d ill=%b mr=%b irw=%b pcw=%b rw=%b mw=%b want 10 1 0 0 0 0 0",
                 i, state_o, illegal_o, mem_read, ir_write, pc_write, reg_write, mem_write);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 4'd0 || illegal_o !== 1'b0 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_reset_exit: state=%0d ill=%b mr=%b want 0 0 1", state_o, illegal_o, mem_read);
    end
`else
    n_checks++;
    if (state_o !== 4'd0 || illegal_o !== 1'b0 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_nop: state=%0d ill=%b mr=%b want 0 0 1", state_o, illegal_o, mem_read);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_sub_addi();
    test_alu_funcs();
    test_lw_stall();
    test_sw_fetch_stall();
    test_branches();
    test_reset_mid_memwrite();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle RV32I variant of the core: one shared ALU, one unified instruction/data memory port, and architectural holding registers (IR, OldPC, ALUOut, Data).
- A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback states, driving mux selects and write enables per state.
- Supports lw, sw, R-type ALU, I-type ALU, and beq/bne/blt.
- Sits between the instruction register and the datapath.
- Stalls on a memory-ready handshake.

Parameters:
- None. All encodings come from the shared package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU result == 0
- signflag  in  1  ALU result[31]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
- imm_src  out  2  00=I, 01=S, 10=B
- reg_write  out  1  register file write enable
- alu_control  out  3  000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and
- state_o  out  4  current state, for debug
- illegal_o  out  1  illegal opcode flag (only with the optional feature)

Behaviour:
- Reset:
  - state=FETCH.
  - While rst is high, every output is 0, including mem_read and state_o=0.
  - Reset asserted mid-instruction aborts it immediately. No write enable may be high in the cycle after rst rises.
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, HALT=10.
- Outputs not listed for a state are 0.
- FETCH:
  - adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=01, imm_src=10, add. This precomputes the branch target into ALUOut.
  - Next state: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; any other op -> FETCH.
- MEMADR:
  - alu_src_a=10, alu_src_b=01, add.
  - imm_src=01 if op[5]=1, else 00.
  - Next: op[5]=1 -> MEMWRITE, else MEMREAD.
- MEMREAD: adr_src=1, mem_read=1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Holds until mem_ready, then FETCH.
  - mem_write stays asserted for every stalled cycle.
- EXECR: alu_src_a=10, alu_src_b=00, ALU function decoded. Then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, ALU function decoded. Then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = (funct3==000 & zero) | (funct3==001 & ~zero) | (funct3==100 & signflag).
  - Any other funct3 gives pc_write=0. Always returns to FETCH.
- ALU function decode (EXECR/EXECI):
  - funct3 000: sub if op[5] & funct7b5, else add.
  - 001 -> sll; 100 -> xor; 101 -> srl; 110 -> or; 111 -> and.
  - 010/011 -> add.
- Combinational outputs: pc_write and ir_write in FETCH and pc_write in BRANCH depend on inputs. All other outputs are functions of state only.
- Latency in cycles, with mem_ready=1 every cycle: lw 5, sw 4, R/I 4, branch 3.

Optional Feature:
- Macro: MCFSM_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported op in DECODE goes to HALT.
  - HALT holds all enables at 0 and illegal_o=1, and is left only by rst.
- Undefined:
  - An unsupported op returns to FETCH as a NOP.
  - HALT is unreachable; illegal_o is tied to 0.

Decomposition:
- Package mcfsm_pkg holds:
  - state encodings;
  - opcode constants (LW, SW, RTYPE, ITYPE, BRANCH);
  - alu_control codes;
  - result_src, alu_src_a, alu_src_b and imm_src select codes.
- One combinational sub-module, mc_alu_func_decode, maps (op[5], funct3, funct7b5) to alu_control. It is used in EXECR/EXECI only.

Test Plan:
- rst pulsed mid-MEMWRITE with mem_ready=0 -> mem_write drops to 0 asynchronously; after release state_o=0 and mem_read=1.
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 -> states 0,1,6,8; alu_control 000; reg_write=1 only in ALUWB.
- sub R-type (f7b5=1) -> alu_control 010 in EXECR; addi with f7b5=1 -> alu_control 000 in EXECI.
- lw with mem_ready low for 3 cycles in MEMREAD -> state stays 3 for 4 cycles, then 4; result_src=01, reg_write=1.
- bne (f3 001) with zero=0 -> pc_write=1 in BRANCH; same with zero=1 -> pc_write=0; blt with signflag=1 -> pc_write=1.
- op 1111111 -> FETCH after DECODE without the macro; HALT with illegal_o=1 and no further fetch with the macro.
